// File: rtl/scope_pkg.sv
// Shared types and default constants for the scope capture controller.
package scope_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    HOLD      = 2'd3
  } scope_state_t;

  localparam int DEF_SAMPLE_W = 16;
  localparam int DEF_ADDR_W   = 10;
  localparam int DEF_NSAMP    = 640;

endpackage

// File: rtl/scope_trig_detect.sv
// Slope trigger detector: keeps the previous sample and compares it, signed,
// against the trigger level; registers the one-cycle triggered pulse.
module scope_trig_detect
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       clear,
  input  logic                       sample_en,
  input  logic                       force_trig,
  input  logic                       slope,
  input  logic signed [SAMPLE_W-1:0] level,
  input  logic signed [SAMPLE_W-1:0] cur,
  output logic                       hit,
  output logic                       triggered
);

  logic signed [SAMPLE_W-1:0] prev;
  logic                       prev_valid;
  logic                       rise;
  logic                       fall;

  // Edge qualification; the first sample after entry only primes prev
  always_comb begin
    rise = (prev < level) && (cur >= level);
    fall = (prev > level) && (cur <= level);
    hit  = 1'b0;
    if (sample_en) begin
      hit = force_trig || (prev_valid && (slope ? fall : rise));
    end else begin
      hit = 1'b0;
    end
  end

  // Previous-sample history and registered trigger pulse
  always_ff @(posedge clk) begin
    if (resetn) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      triggered  <= 1'b0;
    end else begin
      triggered <= hit;
      if (clear) begin
        prev_valid <= 1'b0;
      end else if (sample_en) begin
        prev       <= cur;
        prev_valid <= 1'b1;
      end else begin
        prev_valid <= prev_valid;
      end
    end
  end

endmodule

// File: rtl/scope_capture_ctrl.sv
// Oscilloscope capture controller: trigger search, NSAMP-sample buffer fill, hold
// until the display acknowledges. Optional auto-trigger via SCOPE_AUTOTRIG_EN.
module scope_capture_ctrl
  import scope_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NSAMP    = DEF_NSAMP,
  parameter int TIMEOUT  = 4096
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       arm,
  input  logic                       channel_sel,
  input  logic signed [SAMPLE_W-1:0] trig_level,
  input  logic                       trig_slope,
  input  logic                       s_valid,
  input  logic signed [SAMPLE_W-1:0] s_left,
  input  logic signed [SAMPLE_W-1:0] s_right,
  input  logic                       disp_ack,
  output logic                       wr_en,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [SAMPLE_W-1:0]        wr_data,
  output logic                       busy,
  output logic                       done,
  output logic                       triggered
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NSAMP - 1);

  scope_state_t               state;
  logic [ADDR_W-1:0]          addr_cnt;
  logic signed [SAMPLE_W-1:0] cur;
  logic                       sample_en;
  logic                       clear;
  logic                       hit;
  logic                       force_trig;

  assign cur       = channel_sel ? s_right : s_left;
  assign sample_en = enable && s_valid && (state == WAIT_TRIG);
  assign clear     = (!enable) || (state != WAIT_TRIG);

`ifdef SCOPE_AUTOTRIG_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts strobes seen while searching; the TIMEOUT-th one forces a trigger
  always_ff @(posedge clk) begin
    if (resetn) begin
      to_cnt <= '0;
    end else if (clear) begin
      to_cnt <= '0;
    end else if (s_valid) begin
      to_cnt <= to_cnt + TO_W'(1);
    end else begin
      to_cnt <= to_cnt;
    end
  end

  assign force_trig = (to_cnt == TO_W'(TIMEOUT - 1));
`else
  assign force_trig = 1'b0;
`endif

  scope_trig_detect #(
    .SAMPLE_W (SAMPLE_W)
  ) u_trig (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .sample_en  (sample_en),
    .force_trig (force_trig),
    .slope      (trig_slope),
    .level      (trig_level),
    .cur        (cur),
    .hit        (hit),
    .triggered  (triggered)
  );

  // Main FSM; write strobe and status flags are registered with the state
  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= IDLE;
      addr_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state <= WAIT_TRIG;
              busy  <= 1'b1;
            end
          end
          WAIT_TRIG: begin
            if (hit) begin
              wr_en    <= 1'b1;
              wr_addr  <= '0;
              wr_data  <= cur;
              addr_cnt <= ADDR_W'(1);
              if (NSAMP == 1) begin
                state <= HOLD;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
          CAPTURE: begin
            if (s_valid) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_cnt;
              wr_data <= cur;
              // Stop at the last slot; the address never wraps
              if (addr_cnt == LAST_ADDR) begin
                state <= HOLD;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                addr_cnt <= addr_cnt + ADDR_W'(1);
              end
            end
          end
          HOLD: begin
            if (disp_ack || arm) begin
              state <= WAIT_TRIG;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_scope_capture_ctrl.sv
// Self-checking bench for scope_capture_ctrl: vector table plus capture sequences.
module tb_scope_capture_ctrl;

  logic               clk = 1'b0;
  logic               resetn;
  logic               enable;
  logic               arm;
  logic               channel_sel;
  logic signed [15:0] trig_level;
  logic               trig_slope;
  logic               s_valid;
  logic signed [15:0] s_left;
  logic signed [15:0] s_right;
  logic               disp_ack;
  logic               wr_en;
  logic [9:0]         wr_addr;
  logic [15:0]        wr_data;
  logic               busy;
  logic               done;
  logic               triggered;

  int checks = 0;
  int errors = 0;

  scope_capture_ctrl #(
    .SAMPLE_W (16),
    .ADDR_W   (10),
    .NSAMP    (640),
    .TIMEOUT  (8)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .enable      (enable),
    .arm         (arm),
    .channel_sel (channel_sel),
    .trig_level  (trig_level),
    .trig_slope  (trig_slope),
    .s_valid     (s_valid),
    .s_left      (s_left),
    .s_right     (s_right),
    .disp_ack    (disp_ack),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
    .triggered   (triggered)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en, arm, ch, slope, sv, ack;
    logic [15:0] lvl, l, r;
    logic        ewr;
    logic [9:0]  eaddr;
    logic [15:0] edata;
    logic        ebusy, edone, etrig;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int en, input int a, input int ch, input int sl, input int lvl,
                              input int sv, input int l, input int r, input int ack,
                              input int ewr, input int eaddr, input int edata,
                              input int ebusy, input int edone, input int etrig);
    vec_t v;
    v.en = 1'(en); v.arm = 1'(a); v.ch = 1'(ch); v.slope = 1'(sl); v.lvl = 16'(lvl);
    v.sv = 1'(sv); v.l = 16'(l); v.r = 16'(r); v.ack = 1'(ack);
    v.ewr = 1'(ewr); v.eaddr = 10'(eaddr); v.edata = 16'(edata);
    v.ebusy = 1'(ebusy); v.edone = 1'(edone); v.etrig = 1'(etrig);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input int en, input int a, input int ch, input int sl, input int lvl,
                       input int sv, input int l, input int r, input int ack);
    enable = 1'(en); arm = 1'(a); channel_sel = 1'(ch); trig_slope = 1'(sl);
    trig_level = 16'(lvl); s_valid = 1'(sv); s_left = 16'(l); s_right = 16'(r); disp_ack = 1'(ack);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int value);
    drive(1, 0, 0, 0, 0, 1, value, 0, 0);
    tick();
  endtask

  task automatic gap();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    int nwr;
    int seen;

    // Rising trigger, capture, enable drop
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,-5,0,0,     0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,-1,0,0,     0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,3,0,0,      1,0,3,   1,0,1));
    vecs.push_back(mk(1,0,0,0,0,   0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,10,0,0,     1,1,10,  1,0,0));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,      0,0,0,   0,0,0));
    // Falling trigger on right channel, left ignored
    vecs.push_back(mk(1,1,1,1,100, 0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,1,1,100, 1,0,200,0,    0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,1,1,100, 1,500,100,0,  1,0,100, 1,0,1));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,      0,0,0,   0,0,0));
    // Stale negative prev must not survive a re-arm
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,-7,0,0,     0,0,0,   1,0,0));
    vecs.push_back(mk(0,0,0,0,0,   0,0,0,0,      0,0,0,   0,0,0));
    vecs.push_back(mk(1,1,0,0,0,   0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,-1,0,0,     0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,0,   1,0,0,0,      1,0,0,   1,0,1));
    vecs.push_back(mk(1,1,0,0,0,   1,5,0,0,      1,1,5,   1,0,0));
    vecs.push_back(mk(0,0,0,0,0,   1,9,0,0,      0,0,0,   0,0,0));
    // Signed compare with a negative level
    vecs.push_back(mk(1,1,0,0,-10, 0,0,0,0,      0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,-10, 1,-20,0,0,    0,0,0,   1,0,0));
    vecs.push_back(mk(1,0,0,0,-10, 1,5,0,0,      1,0,5,   1,0,1));
    vecs.push_back(mk(0,1,0,0,0,   0,0,0,0,      0,0,0,   0,0,0));
    vecs.push_back(mk(0,1,0,0,0,   0,0,0,0,      0,0,0,   0,0,0));

    // Reset state with busy-looking inputs applied
    resetn = 1'b1;
    drive(1, 1, 0, 0, 0, 1, 5, 0, 1);
    repeat (3) tick();
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    resetn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].arm, vecs[i].ch, vecs[i].slope, int'($signed(vecs[i].lvl)),
            vecs[i].sv, int'($signed(vecs[i].l)), int'($signed(vecs[i].r)), vecs[i].ack);
      tick();
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].ewr));
      check($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].ebusy));
      check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].edone));
      check($sformatf("v%0d_trig", i), 32'(triggered), 32'(vecs[i].etrig));
      if (vecs[i].ewr) begin
        check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].eaddr));
        check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].edata));
      end
    end

    // Full 640-sample capture, HOLD behaviour, ack+arm re-arm
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    sample(-1);
    sample(0);
    check("full_first_wr", 32'(wr_en), 32'd1);
    check("full_first_addr", 32'(wr_addr), 32'd0);
    check("full_first_trig", 32'(triggered), 32'd1);
    for (int k = 1; k < 640; k++) begin
      gap();
      sample(k);
      check($sformatf("full_wr_%0d", k), 32'(wr_en), 32'd1);
      check($sformatf("full_addr_%0d", k), 32'(wr_addr), 32'(k));
      check($sformatf("full_data_%0d", k), 32'(wr_data), 32'(k));
    end
    check("full_done", 32'(done), 32'd1);
    check("full_busy", 32'(busy), 32'd0);
    sample(1234);
    check("hold_no_write", 32'(wr_en), 32'd0);
    check("hold_done", 32'(done), 32'd1);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    check("ack_arm_busy", 32'(busy), 32'd1);
    check("ack_arm_done", 32'(done), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("ack_arm_off_busy", 32'(busy), 32'd0);

    // Enable dropped right after the 300th write
    nwr = 0;
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    sample(-1);
    for (int k = 0; k < 300; k++) begin
      sample(k);
      if (wr_en) nwr++;
      check($sformatf("drop_addr_%0d", k), 32'(wr_addr), 32'(k));
    end
    drive(0, 0, 0, 0, 0, 1, 300, 0, 0);
    tick();
    if (wr_en) nwr++;
    check("drop_no_write", 32'(wr_en), 32'd0);
    check("drop_busy", 32'(busy), 32'd0);
    sample(301);
    if (wr_en) nwr++;
    check("drop_write_count", 32'(nwr), 32'd300);
    check("drop_idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of a capture
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    sample(-1);
    sample(0);
    sample(1);
    check("mid_rst_pre_wr", 32'(wr_en), 32'd1);
    resetn = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 2, 0, 0);
    tick();
    check("mid_rst_wr", 32'(wr_en), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_addr", 32'(wr_addr), 32'd0);
    resetn = 1'b0;
    sample(3);
    check("post_rst_wr", 32'(wr_en), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

`ifdef SCOPE_AUTOTRIG_EN
    // Constant input forces a trigger on the 8th strobe
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      sample(7);
      check($sformatf("auto_trig_%0d", i), 32'(triggered), 32'(i == 8));
      check($sformatf("auto_wr_%0d", i), 32'(wr_en), 32'(i == 8));
    end
    check("auto_addr0", 32'(wr_addr), 32'd0);
    sample(8);
    check("auto_next_addr", 32'(wr_addr), 32'd1);
    check("auto_next_data", 32'(wr_data), 32'd8);
`else
    // Without auto-trigger a flat signal never fires
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    seen = 0;
    for (int i = 0; i < 10000; i++) begin
      sample(7);
      if (triggered || wr_en) seen++;
    end
    check("no_autotrig_events", 32'(seen), 32'd0);
    check("no_autotrig_busy", 32'(busy), 32'd1);
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
